mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter for the core's single memory port: one address bus, one write-data bus, one write enable and a shared read-data return.
- Master 0 is the core's memory interface. Master 1 is a second bus master (program loader / debug / DMA).
- Round-robin arbitration, one outstanding transaction at a time, fixed memory read latency.
- Sits between the masters and the memory model; the memory sees exactly one master per transaction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from address presented to mem_data_in valid; legal range 1..8.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 grant pulse.
- m0_rvalid  out  1  master 0 completion pulse.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- mem_address  out  ADDR_W  memory address.
- mem_data_out  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_data_in  in  DATA_W  memory read data.
- busy  out  1  transaction in progress (state != IDLE).
- owner  out  1  index of the current or last winner.

Behaviour:
- Reset (clk, reset: one clock; reset is synchronous and active-high):
  - state=IDLE, last_owner=1 so m0 wins the first tie.
  - All outputs 0, including rdata registers, mem_address and mem_data_out.
- States:
  - IDLE -> ISSUE when any req is sampled high.
  - ISSUE -> WAIT for a read, -> DONE for a write.
  - WAIT: counter loaded with RD_LAT-1; -> DONE when the counter is 0 (WAIT lasts exactly RD_LAT cycles).
  - DONE -> IDLE, unconditionally.
- Arbitration happens only in IDLE:
  - Single requester wins.
  - Both requesting: the master != last_owner wins.
  - On the capture edge, addr/we/wdata of the winner are registered, owner=winner and last_owner=winner.
- Timing (capture edge at end of cycle N):
  - Cycle N+1 (ISSUE): mX_gnt=1 for exactly this one cycle; mem_address and mem_data_out are driven from the captured values; mem_we=1 only in this cycle and only for writes.
  - mem_address and mem_data_out stay stable from ISSUE through DONE and keep their last value in IDLE.
  - mem_we=0 in every state except ISSUE.
- Read completion:
  - mem_data_in is sampled at the end of the last WAIT cycle (cycle N+1+RD_LAT) into the owner's rdata register.
  - mX_rvalid=1 in DONE (cycle N+2+RD_LAT).
- Write completion: mX_rvalid=1 in DONE (cycle N+2); rdata unchanged.
- Throughput: read = 3+RD_LAT cycles per transaction; write = 3 cycles per transaction.
- Non-owner outputs: gnt and rvalid of the non-owner are always 0. Each mX_rdata holds its value until that master's next read.
- Master protocol:
  - Hold req/addr/we/wdata stable until gnt; may drop req in the gnt cycle.
  - A req high in ISSUE/WAIT/DONE is not acted on until the next IDLE.
  - A request sampled in IDLE is committed even if the master drops req afterwards.
- Reset mid-transaction:
  - Transaction abandoned; return to IDLE.
  - No gnt/rvalid pulse; mem_we=0 on the next cycle.
  - last_owner=1.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - Adds inputs m0_lock and m1_lock (1 bit each).
  - If the winner's lock is high at the capture edge, lock_hold=1.
  - In IDLE with lock_hold=1 and owner's lock still high: only the owner's req is considered; the other master waits, even if the owner is idle.
  - lock_hold clears in IDLE when the owner's lock is low; normal round-robin then applies in that same cycle.
  - Reset clears lock_hold.
- Undefined: no lock ports, no lock_hold register; pure round-robin.

Test Plan:
1. Reset asserted 3 cycles -> all outputs 0, busy=0, owner=0; a lone m1 read then gets m1_gnt, proving reset does not block arbitration.
2. RD_LAT=2, m0 read 0x100, memory returns 0xDEADBEEF -> m0_gnt in cycle 1, mem_address=0x100 in cycles 1-3, m0_rvalid with m0_rdata=0xDEADBEEF in cycle 4, mem_we=0 throughout.
3. m1 write 0x200/0x12345678 -> mem_we=1 only in cycle 1 with mem_address=0x200 and mem_data_out=0x12345678; m1_rvalid in cycle 2; m1_rdata unchanged.
4. m0 and m1 both request reads continuously, 6 transactions -> grants m0,m1,m0,m1,m0,m1; never both gnt in one cycle.
5. Reset pulse during WAIT of an m1 read -> no m1_rvalid; then simultaneous requests -> m0 granted first.
6. MEM_ARB_LOCK_EN defined, m1_lock=1, both requesting -> three consecutive m1 grants; drop m1_lock -> next grant goes to m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for a single memory port.
//
// One transaction is in flight at a time: IDLE -> ISSUE -> (WAIT x RD_LAT) -> DONE
// for reads, and IDLE -> ISSUE -> DONE for writes. Arbitration is done only in IDLE.
// The winner's addr/we/wdata are captured on the edge that leaves IDLE, so the
// memory-side outputs stay stable for the whole transaction and keep their last
// value afterwards.
//
// Optional feature: define MEM_ARB_LOCK_EN to add m0_lock/m1_lock. A winner that
// holds its lock keeps exclusive ownership of the port, even while it is idle,
// until it drops the lock.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   mX_req/we/addr/wdata         master X request (X = 0 core, 1 loader/debug/DMA)
//   mX_gnt                       one-cycle grant pulse (ISSUE cycle)
//   mX_rvalid                    one-cycle completion pulse (DONE cycle)
//   mX_rdata                     per-master read data, held until that master's next read
//   mem_address/data_out/we      memory request side
//   mem_data_in                  memory read data, valid RD_LAT cycles after address
//   busy                         a transaction is in progress
//   owner                        current or most recent winner
//   m0_lock, m1_lock             (MEM_ARB_LOCK_EN only) bus-lock requests

// Per-master return path: grant/completion pulses and the read-data register.
module mem_arb_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel_i,        // this master owns the current transaction
  input  logic              issue_i,      // FSM in ISSUE
  input  logic              done_i,       // FSM in DONE
  input  logic              rd_sample_i,  // last WAIT cycle: memory data valid
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (sel_i && rd_sample_i) rdata_d = mem_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign gnt_o    = sel_i & issue_i;
  assign rvalid_o = sel_i & done_i;
  assign rdata_o  = rdata_q;
endmodule

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1    // 1..8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MEM_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              busy,
  output logic              owner
);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, last_owner_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               we_q;

  logic [1:0]             req_w, we_w, req_eff;
  logic [1:0][ADDR_W-1:0] addr_w;
  logic [1:0][DATA_W-1:0] wdata_w;
  logic                   winner, capture;

  assign req_w   = {m1_req, m0_req};
  assign we_w    = {m1_we, m0_we};
  assign addr_w  = {m1_addr, m0_addr};
  assign wdata_w = {m1_wdata, m0_wdata};

`ifdef MEM_ARB_LOCK_EN
  logic [1:0] lock_w;
  logic       lock_hold_q, lock_hold_d, locked;

  assign lock_w = {m1_lock, m0_lock};
  // Lock only bites while the holder still asserts it; otherwise plain round-robin.
  assign locked = lock_hold_q && lock_w[owner_q];

  always_comb begin
    req_eff = req_w;
    if (locked) req_eff[~owner_q] = 1'b0;
  end

  always_comb begin
    lock_hold_d = lock_hold_q;
    if (state_q == S_IDLE && !locked) lock_hold_d = 1'b0;
    if (capture) lock_hold_d = lock_w[winner];
  end

  always_ff @(posedge clk) begin
    if (reset) lock_hold_q <= 1'b0;
    else       lock_hold_q <= lock_hold_d;
  end
`else
  assign req_eff = req_w;
`endif

  // Tie goes to whoever did not win last; a lone requester simply wins.
  assign winner = (req_eff == 2'b11) ? ~last_owner_q : req_eff[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_eff != 2'b00) begin
          state_d = S_ISSUE;
          capture = 1'b1;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;   // m0 wins the first tie
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        owner_q      <= winner;
        last_owner_q <= winner;
        addr_q       <= addr_w[winner];
        wdata_q      <= wdata_w[winner];
        we_q         <= we_w[winner];
      end
    end
  end

  logic                   issue, done, rd_sample;
  logic [1:0]             gnt_w, rvalid_w;
  logic [1:0][DATA_W-1:0] rdata_w;

  assign issue     = (state_q == S_ISSUE);
  assign done      = (state_q == S_DONE);
  assign rd_sample = (state_q == S_WAIT) && (cnt_q == '0);

  for (genvar g = 0; g < 2; g++) begin : g_port
    mem_arb_port #(.DATA_W(DATA_W)) u_port (
      .clk         (clk),
      .reset       (reset),
      .sel_i       (owner_q == 1'(g)),
      .issue_i     (issue),
      .done_i      (done),
      .rd_sample_i (rd_sample),
      .mem_rdata_i (mem_data_in),
      .gnt_o       (gnt_w[g]),
      .rvalid_o    (rvalid_w[g]),
      .rdata_o     (rdata_w[g])
    );
  end

  assign m0_gnt    = gnt_w[0];
  assign m1_gnt    = gnt_w[1];
  assign m0_rvalid = rvalid_w[0];
  assign m1_rvalid = rvalid_w[1];
  assign m0_rdata  = rdata_w[0];
  assign m1_rdata  = rdata_w[1];

  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;
  assign mem_we       = issue & we_q;
  assign busy         = (state_q != S_IDLE);
  assign owner        = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (RD_LAT=2). A transaction-level model predicts every
// output from the capture cycle and transaction length; directed tests add
// hand-computed literal expectations. Build with MEM_ARB_LOCK_EN to add the lock test.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, RD_LAT = 2;

  logic          clk, reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out, mem_data_in;
  logic          mem_we, busy, owner;
`ifdef MEM_ARB_LOCK_EN
  logic          m0_lock, m1_lock;
`endif

  int checks = 0, errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_we(mem_we),
    .mem_data_in(mem_data_in), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT: combinational read, write on mem_we.
  logic [DW-1:0] mem [256];
  assign mem_data_in = mem[mem_address[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_address[9:2]] <= mem_data_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit [DW-1:0] mmem [256];
  bit [DW-1:0] mrd [2];
  bit          mact, mwe, mtm, mlast, mown, mlh, chk_en;
  bit [AW-1:0] maddr;
  bit [DW-1:0] mwd;
  int          cyc, mcap, mlen;

  always @(posedge clk) begin
    int ph;
    bit r0, r1, w;
    ph = cyc - mcap;
    if (mact && mwe && ph == 1) mmem[maddr[9:2]] = mwd;
    if (reset) begin
      mact = 0; mlast = 1; mown = 0; maddr = '0; mwd = '0;
      mrd[0] = '0; mrd[1] = '0; mlh = 0; chk_en = 1;
    end else begin
      if (mact && !mwe && ph == 1 + RD_LAT) mrd[mtm] = mmem[maddr[9:2]];
      if (!(mact && ph >= 1 && ph <= mlen)) begin
        r0 = m0_req; r1 = m1_req;
`ifdef MEM_ARB_LOCK_EN
        if (mlh && (mown ? m1_lock : m0_lock)) begin
          if (mown) r0 = 0; else r1 = 0;
        end else mlh = 0;
`endif
        if (r0 || r1) begin
          w = (r0 && r1) ? !mlast : r1;
          mact = 1; mcap = cyc; mtm = w; mlast = w; mown = w;
          mwe   = w ? m1_we : m0_we;
          maddr = w ? m1_addr : m0_addr;
          mwd   = w ? m1_wdata : m0_wdata;
          mlen  = mwe ? 2 : 2 + RD_LAT;
`ifdef MEM_ARB_LOCK_EN
          mlh = w ? m1_lock : m0_lock;
`endif
        end
      end
    end
    cyc++;
  end

  // ---------------- compare process ----------------
  int glog[$];
  int rv1_cnt = 0;

  always @(negedge clk) begin
    int  ph;
    bit  a;
    if (chk_en) begin
      ph = cyc - mcap;
      a  = mact && ph >= 1 && ph <= mlen;
      chk("m0_gnt",       64'(m0_gnt),       64'(a && ph == 1 && !mtm));
      chk("m1_gnt",       64'(m1_gnt),       64'(a && ph == 1 && mtm));
      chk("m0_rvalid",    64'(m0_rvalid),    64'(a && ph == mlen && !mtm));
      chk("m1_rvalid",    64'(m1_rvalid),    64'(a && ph == mlen && mtm));
      chk("mem_we",       64'(mem_we),       64'(a && ph == 1 && mwe));
      chk("busy",         64'(busy),         64'(a));
      chk("owner",        64'(owner),        64'(mown));
      chk("mem_address",  64'(mem_address),  64'(maddr));
      chk("mem_data_out", 64'(mem_data_out), 64'(mwd));
      chk("m0_rdata",     64'(m0_rdata),     64'(mrd[0]));
      chk("m1_rdata",     64'(m1_rdata),     64'(mrd[1]));
      chk("one_gnt",      64'(m0_gnt && m1_gnt), 64'(0));
      if (m0_gnt) glog.push_back(0);
      if (m1_gnt) glog.push_back(1);
      if (m1_rvalid) rv1_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_gnts(input int n, input string nm);
    int got = 0, k = 0;
    while (got < n && k < 400) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) got++;
      k++;
    end
    chk(nm, 64'(got), 64'(n));
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [5:0] eg, er, eb, e4;
    logic [4:0] e6;
    for (int i = 0; i < 256; i++) begin
      mmem[i] = 32'hA5A5_0000 + i;
      mem[i] <= 32'hA5A5_0000 + i;
    end
    mmem[8'h40] = 32'hDEAD_BEEF;
    mem[8'h40] <= 32'hDEAD_BEEF;
    reset = 1; m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    m0_lock = 0; m1_lock = 0;
`endif

    // Test 1: reset for 3 cycles, then a lone m1 read of 0x40
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_owner", 64'(owner), 64'(0));
    chk("t1_addr", 64'(mem_address), 64'(0));
    chk("t1_dout", 64'(mem_data_out), 64'(0));
    chk("t1_rd0", 64'(m0_rdata), 64'(0));
    chk("t1_rd1", 64'(m1_rdata), 64'(0));
    chk("t1_we", 64'(mem_we), 64'(0));
    m1_req = 1; m1_we = 0; m1_addr = 32'h40; m1_wdata = 32'h1111;
    wait_gnts(1, "t1_gnt_seen");
    chk("t1_m1gnt", 64'(m1_gnt), 64'(1));
    m1_req = 0;
    drain();
    chk("t1_m1rdata", 64'(m1_rdata), 64'(32'hA5A5_0010));

    // Test 2: m0 read 0x100 -> DEADBEEF, cycle-by-cycle
    eg = 6'b000010; er = 6'b010000; eb = 6'b011110;
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_wdata = 32'h2222;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_gnt", 64'(m0_gnt), 64'(eg[i]));
      chk("t2_rvalid", 64'(m0_rvalid), 64'(er[i]));
      chk("t2_busy", 64'(busy), 64'(eb[i]));
      chk("t2_we", 64'(mem_we), 64'(0));
      if (i >= 1 && i <= 4) chk("t2_addr", 64'(mem_address), 64'(32'h100));
      if (i == 4) chk("t2_rdata", 64'(m0_rdata), 64'(32'hDEAD_BEEF));
      if (i == 1) m0_req = 0;
    end

    // Test 3: m1 write 0x200 <- 0x12345678
    eg = 6'b000010; er = 6'b000100; eb = 6'b000110;
    @(posedge clk); #1;
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_gnt", 64'(m1_gnt), 64'(eg[i]));
      chk("t3_we", 64'(mem_we), 64'(eg[i]));
      chk("t3_rvalid", 64'(m1_rvalid), 64'(er[i]));
      chk("t3_busy", 64'(busy), 64'(eb[i]));
      if (i == 1) begin
        chk("t3_addr", 64'(mem_address), 64'(32'h200));
        chk("t3_dout", 64'(mem_data_out), 64'(32'h1234_5678));
        m1_req = 0;
      end
      if (i == 2) chk("t3_rdata_kept", 64'(m1_rdata), 64'(32'hA5A5_0010));
    end
    drain();
    chk("t3_memword", 64'(mem[8'h80]), 64'(32'h1234_5678));

    // Test 4: both reading continuously -> alternating grants from m0
    base = glog.size();
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    wait_gnts(6, "t4_gnts");
    m0_req = 0; m1_req = 0;
    drain();
    e4 = 6'b101010;
    chk("t4_count", 64'(glog.size() - base), 64'(6));
    for (int k = 0; k < 6; k++)
      if (base + k < glog.size()) chk("t4_order", 64'(glog[base+k]), 64'(e4[k]));
    chk("t4_m1rdata", 64'(m1_rdata), 64'(32'h1234_5678));

    // Test 5: reset during WAIT of an m1 read, then a tie goes to m0
    m1_req = 1; m1_we = 0; m1_addr = 32'h44;
    wait_gnts(1, "t5_gnt");
    m1_req = 0;
    base = rv1_cnt;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    repeat (6) @(negedge clk);
    chk("t5_no_rvalid", 64'(rv1_cnt), 64'(base));
    chk("t5_rdata_clr", 64'(m1_rdata), 64'(0));
    m0_req = 1; m0_addr = 32'h100; m0_we = 0;
    m1_req = 1; m1_addr = 32'h44;
    wait_gnts(1, "t5_gnt2");
    chk("t5_m0first", 64'(m0_gnt), 64'(1));
    m0_req = 0; m1_req = 0;
    drain();

`ifdef MEM_ARB_LOCK_EN
    // Test 6: m1 holds lock -> m0, then three m1 grants, then m0 after unlock
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    base = glog.size();
    m1_lock = 1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    wait_gnts(4, "t6_gnts");
    m1_lock = 0;
    wait_gnts(1, "t6_gnt5");
    m0_req = 0; m1_req = 0;
    drain();
    e6 = 5'b01110;
    chk("t6_count", 64'(glog.size() - base), 64'(5));
    for (int k = 0; k < 5; k++)
      if (base + k < glog.size()) chk("t6_order", 64'(glog[base+k]), 64'(e6[k]));
`else
    e6 = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
